// File: rtl/qdec_pkg.sv
// qdec_pkg: shared constants for the quadrature decoder tile.
// Gray states are {B,A}; the forward rotation is 00 -> 01 -> 11 -> 10 -> 00.
package qdec_pkg;

   localparam logic [1:0] ST_00 = 2'b00;
   localparam logic [1:0] ST_01 = 2'b01;
   localparam logic [1:0] ST_11 = 2'b11;
   localparam logic [1:0] ST_10 = 2'b10;

   // ui_in bit positions
   localparam int unsigned PIN_A    = 0;
   localparam int unsigned PIN_B    = 1;
   localparam int unsigned PIN_HOLD = 2;
   localparam int unsigned PIN_CLR  = 3;

   // uio_out bit positions
   localparam int unsigned PIN_UP  = 0;
   localparam int unsigned PIN_DN  = 1;
   localparam int unsigned PIN_ERR = 2;

   localparam int unsigned FILT_CYCLES_DEF = 3;

   // Successor of a Gray state in the forward direction.
   function automatic logic [1:0] gray_fwd(input logic [1:0] s);
      logic [1:0] n;
      unique case (s)
         ST_00:   n = ST_01;
         ST_01:   n = ST_11;
         ST_11:   n = ST_10;
         default: n = ST_00;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/qdec_sync_filter.sv
// qdec_sync_filter: 2-flop synchroniser plus persistence filter for the {B,A} phases.
// q_upd_o is high in the cycle before the accepting edge so the caller can register the
// decoded step on the same edge that q loads; q_o is the value being accepted and q_prev_o
// the value currently held. init_o rises on the first acceptance after reset (that
// acceptance itself sees init_o low), or once the reset value has been stable for
// FILT_CYCLES cycles.
module qdec_sync_filter
   import qdec_pkg::*;
#(
   parameter int unsigned FILT_CYCLES = FILT_CYCLES_DEF
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [1:0] ab_i,
   output logic [1:0] q_o,
   output logic       q_upd_o,
   output logic [1:0] q_prev_o,
   output logic       init_o
);

   localparam logic [3:0] FiltMax = 4'(FILT_CYCLES);

   logic [1:0] s1_q, s2_q;
   logic [1:0] q_q, q_d;
   logic [1:0] cand_q, cand_d;
   logic [3:0] cnt_q, cnt_d, cnt_inc;
   logic [3:0] stab_q, stab_d, stab_inc;
   logic       init_q, init_d;
   logic       upd;

   // Filter: count cycles a new, unchanging s2 differs from q; accept at FILT_CYCLES.
   always_comb begin
      q_d     = q_q;
      cand_d  = cand_q;
      cnt_d   = '0;
      cnt_inc = '0;
      upd     = 1'b0;
      if (s2_q != q_q) begin
         // A different candidate mid-count restarts the run at 1.
         cnt_inc = (cnt_q == '0 || s2_q != cand_q) ? 4'd1 : cnt_q + 4'd1;
         cand_d  = s2_q;
         if (cnt_inc == FiltMax) begin
            q_d = s2_q;
            upd = 1'b1;
         end else begin
            cnt_d = cnt_inc;
         end
      end
   end

   // Init: set by the first acceptance, or by the reset value holding for FILT_CYCLES.
   always_comb begin
      init_d   = init_q;
      stab_d   = '0;
      stab_inc = stab_q + 4'd1;
      if (!init_q) begin
         if (upd) begin
            init_d = 1'b1;
         end else if (s2_q == q_q) begin
            if (stab_inc == FiltMax) init_d = 1'b1;
            else                     stab_d = stab_inc;
         end
      end
   end

   // Synchroniser, filter and init state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_q   <= '0;
         s2_q   <= '0;
         q_q    <= '0;
         cand_q <= '0;
         cnt_q  <= '0;
         stab_q <= '0;
         init_q <= 1'b0;
      end else begin
         s1_q   <= ab_i;
         s2_q   <= s1_q;
         q_q    <= q_d;
         cand_q <= cand_d;
         cnt_q  <= cnt_d;
         stab_q <= stab_d;
         init_q <= init_d;
      end
   end

   assign q_o      = s2_q;
   assign q_upd_o  = upd;
   assign q_prev_o = q_q;
   assign init_o   = init_q;

endmodule

// File: rtl/tt_um_quad_decoder_shivam.sv
// tt_um_quad_decoder_shivam: quadrature encoder front-end tile. Emits one-cycle up/down
// pulses on uio for a downstream counter, an 8-bit wrapping position on uo_out and a sticky
// illegal-transition flag. Define QDEC_X1_EN for X1 counting (only the 10<->00 step counts);
// the default build counts every legal step (X4).
module tt_um_quad_decoder_shivam
   import qdec_pkg::*;
#(
   parameter int unsigned FILT_CYCLES = FILT_CYCLES_DEF,
   parameter int unsigned POS_W       = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam logic [POS_W-1:0] PosOne = 1;

   logic [1:0]       ctl_s1_q, ctl_s2_q;  // {clear, hold}
   logic [1:0]       acc_ab, acc_prev;
   logic             acc_upd, filt_init;
   logic             step_up, step_dn, step_err;
   logic             hold_s, clr_s;
   logic [POS_W-1:0] pos_q, pos_d;
   logic             err_q, err_d;
   logic             up_q, dn_q;
   logic             unused_inputs;

   qdec_sync_filter #(
      .FILT_CYCLES(FILT_CYCLES)
   ) u_sync_filter (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .ab_i    ({ui_in[PIN_B], ui_in[PIN_A]}),
      .q_o     (acc_ab),
      .q_upd_o (acc_upd),
      .q_prev_o(acc_prev),
      .init_o  (filt_init)
   );

   assign hold_s = ctl_s2_q[0];
   assign clr_s  = ctl_s2_q[1];

   // Step decode on each accepted transition once initialised.
   always_comb begin
      step_up  = 1'b0;
      step_dn  = 1'b0;
      step_err = 1'b0;
      if (acc_upd && filt_init) begin
         if ((acc_ab ^ acc_prev) == 2'b11) begin
            step_err = 1'b1;
`ifdef QDEC_X1_EN
         end else if (acc_prev == ST_10 && acc_ab == ST_00) begin
            step_up = 1'b1;
         end else if (acc_prev == ST_00 && acc_ab == ST_10) begin
            step_dn = 1'b1;
`else
         end else if (acc_ab == gray_fwd(acc_prev)) begin
            step_up = 1'b1;
         end else if (acc_prev == gray_fwd(acc_ab)) begin
            step_dn = 1'b1;
`endif
         end
      end
   end

   // Position and error next state; clear overrides a coincident step.
   always_comb begin
      pos_d = pos_q;
      err_d = err_q;
      if (step_up && !hold_s)      pos_d = pos_q + PosOne;
      else if (step_dn && !hold_s) pos_d = pos_q - PosOne;
      if (step_err) err_d = 1'b1;
      if (clr_s) begin
         pos_d = '0;
         err_d = 1'b0;
      end
   end

   // Control synchroniser, pulse, position and error registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctl_s1_q <= '0;
         ctl_s2_q <= '0;
         pos_q    <= '0;
         err_q    <= 1'b0;
         up_q     <= 1'b0;
         dn_q     <= 1'b0;
      end else begin
         ctl_s1_q <= {ui_in[PIN_CLR], ui_in[PIN_HOLD]};
         ctl_s2_q <= ctl_s1_q;
         pos_q    <= pos_d;
         err_q    <= err_d;
         up_q     <= step_up;
         dn_q     <= step_dn;
      end
   end

   // Output pin mapping.
   always_comb begin
      uio_out          = '0;
      uio_out[PIN_UP]  = up_q;
      uio_out[PIN_DN]  = dn_q;
      uio_out[PIN_ERR] = err_q;
   end

   assign uo_out = pos_q;
   assign uio_oe = 8'b0000_0111;

   assign unused_inputs = ^{ena, uio_in, ui_in[7:4]};

endmodule

// File: tb/tb_tt_um_quad_decoder_shivam.sv
// Scoreboard bench: stimulus tasks run the step model and queue expected pulses; a monitor
// pops and compares whenever the DUT raises up or down.
module tb_tt_um_quad_decoder_shivam;

   localparam int FILT = 3;
   localparam int LAT  = FILT + 2;  // cycles from pin change to visible pulse

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   tt_um_quad_decoder_shivam dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
      .ui_in  (ui_in),
      .uo_out (uo_out),
      .uio_in (uio_in),
      .uio_out(uio_out),
      .uio_oe (uio_oe)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit dn;
      int pos;
      int t;
   } exp_t;

   exp_t sb[$];

   // Reference model state
   bit         m_init;
   logic [1:0] m_ab;
   int         m_pos;
   bit         m_err;
   bit         m_hold;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Position of a Gray state on the forward circle.
   function automatic int gidx(input logic [1:0] s);
      case (s)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   function automatic logic [1:0] at_idx(input int i);
      logic [1:0] tbl [4];
      tbl[0] = 2'b00;
      tbl[1] = 2'b01;
      tbl[2] = 2'b11;
      tbl[3] = 2'b10;
      return tbl[i % 4];
   endfunction

   // Model one accepted pin value driven at cycle c.
   task automatic model_accept(input logic [1:0] nv, input int c);
      int   d;
      bit   counts;
      exp_t e;
      if (!m_init) begin
         m_init = 1'b1;
         m_ab   = nv;
         return;
      end
      if (nv == m_ab) return;
      d = (gidx(nv) - gidx(m_ab) + 4) % 4;
      if (d == 2) begin
         m_err = 1'b1;
      end else begin
`ifdef QDEC_X1_EN
         counts = (d == 1 && gidx(m_ab) == 3) || (d == 3 && gidx(m_ab) == 0);
`else
         counts = 1'b1;
`endif
         if (counts) begin
            if (!m_hold) m_pos = (m_pos + ((d == 3) ? 255 : 1)) % 256;
            e.dn  = (d == 3);
            e.pos = m_pos;
            e.t   = c + LAT;
            sb.push_back(e);
         end
      end
      m_ab = nv;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic step(input logic [1:0] nv, input int hold);
      ui_in[1:0] = nv;
      model_accept(nv, cyc);
      idle(hold);
   endtask

   task automatic quiet_check(input string tag);
      idle(LAT + 3);
      chk({tag, "_pos"}, int'(uo_out), m_pos);
      chk({tag, "_err"}, int'(uio_out[2]), int'(m_err));
   endtask

   task automatic set_hold(input bit h);
      idle(LAT + 2);
      ui_in[2] = h;
      idle(4);
      m_hold = h;
   endtask

   task automatic do_clear();
      idle(LAT + 2);
      ui_in[3] = 1'b1;
      idle(4);
      ui_in[3] = 1'b0;
      idle(4);
      m_pos = 0;
      m_err = 1'b0;
   endtask

   task automatic glitch(input int bitsel, input int len);
      ui_in[bitsel] = ~ui_in[bitsel];
      idle(len);
      ui_in[bitsel] = ~ui_in[bitsel];
      idle(4);
   endtask

   // Monitor: every pulse must match the head of the scoreboard.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && (uio_out[0] || uio_out[1])) begin
         chk("pulse_exclusive", int'(uio_out[0] & uio_out[1]), 0);
         if (sb.size() == 0) begin
            chk("unexpected_pulse_queue_len", 0, 1);
         end else begin
            e = sb.pop_front();
            chk("pulse_dir", int'(uio_out[1]), int'(e.dn));
            chk("pulse_pos", int'(uo_out), e.pos);
            chk("pulse_time", cyc, e.t);
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [1:0] nv;
      m_init = 1'b0;
      m_ab   = 2'b00;
      m_pos  = 0;
      m_err  = 1'b0;
      m_hold = 1'b0;
      rst_n  = 1'b0;
      ena    = 1'b1;
      ui_in  = 8'h00;
      uio_in = 8'h00;
      idle(3);
      chk("reset_pos", int'(uo_out), 0);
      chk("reset_uio_out", int'(uio_out), 0);
      chk("uio_oe", int'(uio_oe), 7);
      rst_n = 1'b1;
      idle(10);
      m_init = 1'b1;  // pins 00 at release: init by stability

      // Directed forward rotation
      step(2'b01, 10);
      step(2'b11, 10);
      step(2'b10, 10);
      step(2'b00, 10);
      quiet_check("fwd4");

      // Reverse from 0 wraps to 255, then 256 forward steps return to 0 (X4)
      do_clear();
      step(2'b10, 8);
      quiet_check("wrap_down");
      step(2'b00, 8);
      quiet_check("wrap_back");
      for (int i = 0; i < 256; i++) step(at_idx(gidx(m_ab) + 1), 4);
      quiet_check("fwd256");

      // Glitches shorter than the filter, then exactly FILT cycles
      glitch(0, 1);
      glitch(0, 2);
      glitch(1, 2);
      quiet_check("glitch");
      nv = at_idx(gidx(m_ab) + 1);
      step(nv, FILT);
      step(at_idx(gidx(m_ab) + 3), 8);
      quiet_check("filt_edge");

      // Double-step jump sets sticky error; clear resets it
      step(m_ab ^ 2'b11, 8);
      quiet_check("jump");
      step(at_idx(gidx(m_ab) + 1), 6);
      quiet_check("sticky");
      do_clear();
      quiet_check("clear");
      chk("clear_pos_zero", int'(uo_out), 0);

      // Hold freezes position but pulses continue
      set_hold(1'b1);
      for (int i = 0; i < 3; i++) step(at_idx(gidx(m_ab) + 1), 6);
      quiet_check("hold");
      set_hold(1'b0);
      step(at_idx(gidx(m_ab) + 1), 6);
      quiet_check("unhold");

      // Randomised walk
      for (int i = 0; i < 200; i++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 3) begin
            step(m_ab ^ 2'b11, int'($urandom_range(4, 8)));
         end else if (r < 8) begin
            glitch(int'($urandom_range(0, 1)), int'($urandom_range(1, 2)));
         end else if (r < 11) begin
            set_hold(~m_hold);
         end else if (r < 13) begin
            do_clear();
         end else begin
            nv = at_idx(gidx(m_ab) + (r[0] ? 1 : 3));
            step(nv, int'($urandom_range(4, 9)));
         end
      end
      set_hold(1'b0);
      quiet_check("random");

      // Reset mid-step: outputs clear at once, first acceptance afterwards is silent
      chk("sb_empty_before_reset", sb.size(), 0);
      nv = at_idx(gidx(m_ab) + 1);
      if (nv == 2'b00) nv = at_idx(gidx(m_ab) + 3);
      ui_in[1:0] = nv;
      idle(2);
      rst_n = 1'b0;
      #1;
      chk("midreset_pos", int'(uo_out), 0);
      chk("midreset_uio", int'(uio_out), 0);
      @(negedge clk);
      rst_n  = 1'b1;
      m_init = 1'b0;
      m_pos  = 0;
      m_err  = 1'b0;
      model_accept(nv, cyc);
      idle(10);
      quiet_check("post_reset");
      for (int i = 0; i < 8; i++) step(at_idx(gidx(m_ab) + 1), 5);
      step(at_idx(gidx(m_ab) + 3), 5);
      quiet_check("post_reset_steps");

      for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
